// File: rtl/mips_pkg.sv
// Shared MIPS32 control constants: opcodes, funct codes, ALU operation codes and FSM states.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package mips_pkg;

  // Opcode field instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Funct field instr[5:0] for R-type
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU operation codes driven on ControlALU
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Main control FSM states; encodings 5 and 6 are unused and recover to IF
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  // True for every opcode the control unit knows how to sequence
  function automatic logic opcode_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: opcode_known = 1'b1;
      default:                                 opcode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_alu.sv
// R-type funct to ALU operation decode, with a flag for recognised funct codes.
// Latency: combinational, zero cycles.
// Backpressure: none.
module control_alu
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       funct_valid_o
);

  // Unknown funct codes fall back to add but are flagged so the FSM can reject them
  always_comb begin
    alu_op_o      = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      F_ADD:   alu_op_o = ALU_ADD;
      F_SUB:   alu_op_o = ALU_SUB;
      F_AND:   alu_op_o = ALU_AND;
      F_OR:    alu_op_o = ALU_OR;
      F_SLT:   alu_op_o = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidad_control.sv
// Multicycle MIPS32 main control FSM: IF/ID/EX/MEM/WB sequencing with all writes in the final state.
// Latency: 3 (BEQ), 4 (R-type, SW, ADDI) or 5 (LW) clocks per instruction; illegal ops trap or take 2 clocks as NOP.
// Backpressure: none; the datapath is assumed to complete every state in one clock.
module unidad_control
  import mips_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instrucc,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       RegDest,
  output logic       FuenteALU,
  output logic       MemaReg,
  output logic       LeerMem,
  output logic       EscrMem,
  output logic       EscrReg,
  output logic       FuentePC,
  output logic       EscrPC,
  output logic [2:0] ControlALU,
  output logic       fin_instr,
  output logic       error,
  output logic [2:0] estado
);

  state_t     estado_q, estado_d;
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic [2:0] alu_rtype;
  logic       funct_valid;
  logic       legal;

  // Write-type strobes before reset gating
  logic       escr_mem_c, escr_reg_c, escr_pc_c, fin_c;

  control_alu u_control_alu (
    .funct_i       (funct_q),
    .alu_op_o      (alu_rtype),
    .funct_valid_o (funct_valid)
  );

  assign legal  = opcode_known(opcode_q) && ((opcode_q != OP_RTYPE) || funct_valid);
  assign estado = estado_q;

  // State register; instruction fields are captured only on the IF->ID edge
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= S_IF;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      estado_q <= estado_d;
      if (estado_q == S_IF) begin
        opcode_q <= instrucc;
        funct_q  <= funct;
      end
    end
  end

  // Next-state sequencing per opcode
  always_comb begin
    estado_d = S_IF;
    case (estado_q)
      S_IF: estado_d = S_ID;
      S_ID: begin
        if (legal)                estado_d = S_EX;
        else if (TRAP_ON_ILLEGAL) estado_d = S_TRAP;
        else                      estado_d = S_IF;
      end
      S_EX: begin
        case (opcode_q)
          OP_RTYPE, OP_ADDI: estado_d = S_WB;
          OP_LW, OP_SW:      estado_d = S_MEM;
          default:           estado_d = S_IF;
        endcase
      end
      S_MEM: estado_d = (opcode_q == OP_LW) ? S_WB : S_IF;
      S_WB:   estado_d = S_IF;
      S_TRAP: estado_d = S_TRAP;
      default: estado_d = S_IF;
    endcase
  end

  // Moore outputs from state and latched fields; only BEQ's EX looks at live zero
  always_comb begin
    RegDest    = 1'b0;
    FuenteALU  = 1'b0;
    MemaReg    = 1'b0;
    LeerMem    = 1'b0;
    FuentePC   = 1'b0;
    ControlALU = ALU_ADD;
    error      = 1'b0;
    escr_mem_c = 1'b0;
    escr_reg_c = 1'b0;
    escr_pc_c  = 1'b0;
    fin_c      = 1'b0;

    // Mux selects stay fixed from ID to the final state of a legal instruction
    if ((estado_q == S_ID || estado_q == S_EX || estado_q == S_MEM || estado_q == S_WB) && legal) begin
      case (opcode_q)
        OP_RTYPE: begin
          RegDest    = 1'b1;
          ControlALU = alu_rtype;
        end
        OP_LW: begin
          FuenteALU = 1'b1;
          MemaReg   = 1'b1;
        end
        OP_SW:   FuenteALU  = 1'b1;
        OP_BEQ:  ControlALU = ALU_SUB;
        OP_ADDI: FuenteALU  = 1'b1;
        default: ;
      endcase
    end

    case (estado_q)
      S_ID: begin
        // Illegal instruction retired as a NOP: just step the PC
        if (!legal && !TRAP_ON_ILLEGAL) begin
          escr_pc_c = 1'b1;
          fin_c     = 1'b1;
        end
      end
      S_EX: begin
        if (opcode_q == OP_LW) LeerMem = 1'b1;
        if (opcode_q == OP_BEQ) begin
          FuentePC  = zero;
          escr_pc_c = 1'b1;
          fin_c     = 1'b1;
        end
      end
      S_MEM: begin
        if (opcode_q == OP_LW) LeerMem = 1'b1;
        if (opcode_q == OP_SW) begin
          escr_mem_c = 1'b1;
          escr_pc_c  = 1'b1;
          fin_c      = 1'b1;
        end
      end
      S_WB: begin
        escr_reg_c = 1'b1;
        escr_pc_c  = 1'b1;
        fin_c      = 1'b1;
      end
      S_TRAP: error = 1'b1;
      default: ;
    endcase
  end

  // A reset landing on a final state must not let that state's writes through
  assign EscrMem   = escr_mem_c & ~reset;
  assign EscrReg   = escr_reg_c & ~reset;
  assign EscrPC    = escr_pc_c  & ~reset;
  assign fin_instr = fin_c      & ~reset;

endmodule

// File: tb/tb_unidad_control.sv
// Directed self-checking bench for unidad_control, both trap and NOP illegal-instruction variants.
// Latency: checks every clock of each instruction sequence.
// Backpressure: none.
module tb_unidad_control;

  logic       clk;
  logic       reset;
  logic [5:0] instrucc;
  logic [5:0] funct;
  logic       zero;

  logic       t_regdest, t_fuentealu, t_memareg, t_leermem, t_escrmem, t_escrreg;
  logic       t_fuentepc, t_escrpc, t_fin, t_error;
  logic [2:0] t_alu, t_estado;
  logic       n_regdest, n_fuentealu, n_memareg, n_leermem, n_escrmem, n_escrreg;
  logic       n_fuentepc, n_escrpc, n_fin, n_error;
  logic [2:0] n_alu, n_estado;

  int n_cmp = 0;
  int n_err = 0;

  unidad_control #(.TRAP_ON_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .instrucc(instrucc), .funct(funct), .zero(zero),
    .RegDest(t_regdest), .FuenteALU(t_fuentealu), .MemaReg(t_memareg),
    .LeerMem(t_leermem), .EscrMem(t_escrmem), .EscrReg(t_escrreg),
    .FuentePC(t_fuentepc), .EscrPC(t_escrpc), .ControlALU(t_alu),
    .fin_instr(t_fin), .error(t_error), .estado(t_estado)
  );

  unidad_control #(.TRAP_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .reset(reset), .instrucc(instrucc), .funct(funct), .zero(zero),
    .RegDest(n_regdest), .FuenteALU(n_fuentealu), .MemaReg(n_memareg),
    .LeerMem(n_leermem), .EscrMem(n_escrmem), .EscrReg(n_escrreg),
    .FuentePC(n_fuentepc), .EscrPC(n_escrpc), .ControlALU(n_alu),
    .fin_instr(n_fin), .error(n_error), .estado(n_estado)
  );

  // Output snapshot layout: {rd,fa,mr,lm,em,er,fpc,epc,alu[2:0],fin,err,st[2:0]}
  logic [15:0] obs_t, obs_n;
  assign obs_t = {t_regdest, t_fuentealu, t_memareg, t_leermem, t_escrmem, t_escrreg,
                  t_fuentepc, t_escrpc, t_alu, t_fin, t_error, t_estado};
  assign obs_n = {n_regdest, n_fuentealu, n_memareg, n_leermem, n_escrmem, n_escrreg,
                  n_fuentepc, n_escrpc, n_alu, n_fin, n_error, n_estado};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [2:0] st, input logic rd, input logic fa,
                                     input logic mr, input logic lm, input logic em,
                                     input logic er, input logic fpc, input logic epc,
                                     input logic [2:0] alu, input logic fin, input logic err);
    mk = {rd, fa, mr, lm, em, er, fpc, epc, alu, fin, err, st};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Check the trap instance mid-cycle, then move to just after the next rising edge
  task automatic cyc(input string tag, input logic [15:0] exp_t);
    @(negedge clk);
    chk(tag, obs_t, exp_t);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input string tag, input logic [15:0] exp_t, input logic [15:0] exp_n);
    @(negedge clk);
    chk(tag, obs_t, exp_t);
    chk({tag, "_nop"}, obs_n, exp_n);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] if_base;

  initial begin
    if_base  = mk(3'd0, 0,0,0,0,0,0,0,0, 3'b010, 0,0);
    reset    = 1'b1;
    instrucc = 6'b000000;
    funct    = 6'b000000;
    zero     = 1'b0;
    @(posedge clk);
    #1;
    cyc2("reset", if_base, if_base);
    reset = 1'b0;

    // LW: 5 clocks, reads in EX and MEM, writes in WB
    instrucc = 6'b100011;
    cyc2("lw_if", if_base, if_base);
    instrucc = 6'b000000;
    cyc("lw_id",  mk(3'd1, 0,1,1,0,0,0,0,0, 3'b010, 0,0));
    cyc("lw_ex",  mk(3'd2, 0,1,1,1,0,0,0,0, 3'b010, 0,0));
    cyc("lw_mem", mk(3'd3, 0,1,1,1,0,0,0,0, 3'b010, 0,0));
    cyc("lw_wb",  mk(3'd4, 0,1,1,0,0,1,0,1, 3'b010, 1,0));

    // R-type SUB; live opcode/funct change mid-instruction must not matter
    instrucc = 6'b000000;
    funct    = 6'b100010;
    cyc("sub_if", if_base);
    instrucc = 6'b111111;
    funct    = 6'b100101;
    cyc("sub_id", mk(3'd1, 1,0,0,0,0,0,0,0, 3'b110, 0,0));
    instrucc = 6'b101011;
    cyc("sub_ex", mk(3'd2, 1,0,0,0,0,0,0,0, 3'b110, 0,0));
    cyc("sub_wb", mk(3'd4, 1,0,0,0,0,1,0,1, 3'b110, 1,0));

    // BEQ taken: zero high already in ID must not move FuentePC there
    instrucc = 6'b000100;
    zero     = 1'b1;
    cyc("beq1_if", if_base);
    cyc("beq1_id", mk(3'd1, 0,0,0,0,0,0,0,0, 3'b110, 0,0));
    cyc("beq1_ex", mk(3'd2, 0,0,0,0,0,0,1,1, 3'b110, 1,0));

    // BEQ not taken
    zero = 1'b0;
    cyc("beq0_if", if_base);
    cyc("beq0_id", mk(3'd1, 0,0,0,0,0,0,0,0, 3'b110, 0,0));
    cyc("beq0_ex", mk(3'd2, 0,0,0,0,0,0,0,1, 3'b110, 1,0));

    // SW: memory write and completion in MEM
    instrucc = 6'b101011;
    cyc("sw_if",  if_base);
    cyc("sw_id",  mk(3'd1, 0,1,0,0,0,0,0,0, 3'b010, 0,0));
    cyc("sw_ex",  mk(3'd2, 0,1,0,0,0,0,0,0, 3'b010, 0,0));
    cyc("sw_mem", mk(3'd3, 0,1,0,0,1,0,0,1, 3'b010, 1,0));

    // ADDI
    instrucc = 6'b001000;
    cyc("addi_if", if_base);
    cyc("addi_id", mk(3'd1, 0,1,0,0,0,0,0,0, 3'b010, 0,0));
    cyc("addi_ex", mk(3'd2, 0,1,0,0,0,0,0,0, 3'b010, 0,0));
    cyc("addi_wb", mk(3'd4, 0,1,0,0,0,1,0,1, 3'b010, 1,0));

    // Reset during LW's MEM: back to IF, no write-back
    instrucc = 6'b100011;
    cyc("lwr_if", if_base);
    cyc("lwr_id", mk(3'd1, 0,1,1,0,0,0,0,0, 3'b010, 0,0));
    cyc("lwr_ex", mk(3'd2, 0,1,1,1,0,0,0,0, 3'b010, 0,0));
    reset = 1'b1;
    cyc("lwr_rst", mk(3'd3, 0,1,1,1,0,0,0,0, 3'b010, 0,0));
    reset = 1'b0;
    instrucc = 6'b101011;
    cyc("lwr_after", if_base);

    // Reset on SW's MEM: the memory write and PC write are suppressed
    cyc("swr_id", mk(3'd1, 0,1,0,0,0,0,0,0, 3'b010, 0,0));
    cyc("swr_ex", mk(3'd2, 0,1,0,0,0,0,0,0, 3'b010, 0,0));
    reset = 1'b1;
    cyc("swr_rst", mk(3'd3, 0,1,0,0,0,0,0,0, 3'b010, 0,0));
    reset = 1'b0;

    // Illegal opcode: trap instance sticks in TRAP, NOP instance retires in 2 clocks
    instrucc = 6'b111111;
    cyc2("ill_if", if_base, if_base);
    cyc2("ill_id", mk(3'd1, 0,0,0,0,0,0,0,0, 3'b010, 0,0),
                   mk(3'd1, 0,0,0,0,0,0,0,1, 3'b010, 1,0));
    for (int i = 0; i < 12; i++) begin
      cyc2($sformatf("trap_%0d", i), mk(3'd7, 0,0,0,0,0,0,0,0, 3'b010, 0,1),
           (i % 2 == 0) ? if_base : mk(3'd1, 0,0,0,0,0,0,0,1, 3'b010, 1,0));
    end

    // Illegal funct under an R-type opcode on the NOP instance
    reset = 1'b1;
    cyc("trap_rst", mk(3'd7, 0,0,0,0,0,0,0,0, 3'b010, 0,1));
    reset    = 1'b0;
    instrucc = 6'b000000;
    funct    = 6'b000111;
    cyc2("post_rst", if_base, if_base);
    cyc2("badf_id", mk(3'd1, 0,0,0,0,0,0,0,0, 3'b010, 0,0),
                    mk(3'd1, 0,0,0,0,0,0,0,1, 3'b010, 1,0));
    cyc2("badf_nxt", mk(3'd7, 0,0,0,0,0,0,0,0, 3'b010, 0,1), if_base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
